// File: rtl/vga_pkg.sv
// vga_pkg -- shared constants and helpers for the VGA frame-buffer blocks.
//   SCAN_LATENCY : cycles from a scan slot until scan_color shows the pixel.
//   vga_div()    : maps the RESOLUTION string to the pixel-clock divider.
package vga_pkg;

  // Scan slot at t -> address at t+1 -> read data at t+2 -> scan_color at t+3.
  localparam int SCAN_LATENCY = 3;

  // Memory clock cycles per displayed pixel. Unknown strings fall back to the
  // coarsest mode so a typo never starves the writers.
  function automatic int vga_div(input logic [55:0] res);
    if (res == "640x480")
      return 1;
    else if (res == "320x240")
      return 2;
    else
      return 4;
  endfunction

endpackage

// File: rtl/vga_address_translator.sv
// vga_address_translator -- (x, y) to linear frame-buffer address.
//   i_x    : column coordinate
//   i_y    : row coordinate
//   o_addr : y*COLS + x, unsigned, computed and truncated at Mn bits
module vga_address_translator #(
  parameter int nX   = 8,
  parameter int nY   = 7,
  parameter int Mn   = 15,
  parameter int COLS = 160
) (
  input  logic [nX-1:0] i_x,
  input  logic [nY-1:0] i_y,
  output logic [Mn-1:0] o_addr
);

  logic [Mn-1:0] w_x;
  logic [Mn-1:0] w_y;
  logic [Mn-1:0] w_cols;

  assign w_x    = Mn'(i_x);
  assign w_y    = Mn'(i_y);
  assign w_cols = Mn'(COLS);

  // Product and sum stay at Mn bits, so oversized coordinates wrap.
  assign o_addr = (w_y * w_cols) + w_x;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter -- shares a single-port VRAM between VGA scanout and two
// pixel writers.
//
// A phase counter (0..DIV-1, cleared by line_start) marks phase 0 of a visible
// line as a scan slot; every other cycle is offered to the writers with
// round-robin arbitration.
//
// Ports
//   vga_clock, resetn       : clock, asynchronous active-low reset
//   line_start              : one-cycle pulse at horizontal counter wrap
//   scan_active, scan_addr  : scanout read request and address
//   scan_color              : registered pixel for the DAC path
//   reqN_valid/x/y/color    : writer N request (N = 0, 1), held until ready
//   reqN_ready              : combinational grant
//   mem_addr/wdata/we       : registered memory command
//   mem_rdata               : synchronous read data, one cycle after mem_addr
//
// Build option
//   VRAM_ARBITER_CLIP_EN : out-of-range transfers are accepted but not written.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter             RESOLUTION  = "160x120",
  parameter int         COLOR_DEPTH = 3,
  parameter int         nX          = 8,
  parameter int         nY          = 7,
  parameter int         Mn          = 15,
  parameter int         COLS        = 160,
  parameter int         ROWS        = 120
) (
  input  logic                   vga_clock,
  input  logic                   resetn,
  input  logic                   line_start,
  input  logic                   scan_active,
  input  logic [Mn-1:0]          scan_addr,
  output logic [COLOR_DEPTH-1:0] scan_color,
  input  logic                   req0_valid,
  input  logic [nX-1:0]          req0_x,
  input  logic [nY-1:0]          req0_y,
  input  logic [COLOR_DEPTH-1:0] req0_color,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [nX-1:0]          req1_x,
  input  logic [nY-1:0]          req1_y,
  input  logic [COLOR_DEPTH-1:0] req1_color,
  output logic                   req1_ready,
  output logic [Mn-1:0]          mem_addr,
  output logic [COLOR_DEPTH-1:0] mem_wdata,
  output logic                   mem_we,
  input  logic [COLOR_DEPTH-1:0] mem_rdata
);

  localparam int DIV       = vga_div(RESOLUTION);
  localparam int RD_STAGES = SCAN_LATENCY - 1;

  // A frame that does not fit the address space is a configuration error.
  if ((longint'(COLS) * longint'(ROWS)) > (longint'(1) << Mn)) begin : g_frame_check
    $error("vram_arbiter: COLS*ROWS exceeds the Mn-bit address space");
  end

  logic [1:0]             r_phase;
  logic                   r_last_gnt;    // 1: req1 was granted most recently
  logic [RD_STAGES-1:0]   r_rd_pipe;
  logic [Mn-1:0]          r_mem_addr;
  logic [COLOR_DEPTH-1:0] r_mem_wdata;
  logic                   r_mem_we;
  logic [COLOR_DEPTH-1:0] r_scan_color;

  logic                   w_scan_slot;
  logic                   w_write_slot;
  logic                   w_gnt0;
  logic                   w_gnt1;
  logic                   w_transfer;
  logic                   w_wr_en;
  logic [nX-1:0]          w_x;
  logic [nY-1:0]          w_y;
  logic [COLOR_DEPTH-1:0] w_color;
  logic [Mn-1:0]          w_addr;

  assign w_scan_slot  = (r_phase == 2'd0) && scan_active;
  // Gating with resetn keeps the grants low while reset is held.
  assign w_write_slot = resetn && !w_scan_slot;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_write_slot) begin
      if (req0_valid && req1_valid) begin
        if (r_last_gnt)
          w_gnt0 = 1'b1;
        else
          w_gnt1 = 1'b1;
      end else if (req0_valid) begin
        w_gnt0 = 1'b1;
      end else if (req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_transfer = w_gnt0 || w_gnt1;

  assign w_x     = w_gnt1 ? req1_x     : req0_x;
  assign w_y     = w_gnt1 ? req1_y     : req0_y;
  assign w_color = w_gnt1 ? req1_color : req0_color;

  vga_address_translator #(
    .nX   (nX),
    .nY   (nY),
    .Mn   (Mn),
    .COLS (COLS)
  ) u_xlate (
    .i_x    (w_x),
    .i_y    (w_y),
    .o_addr (w_addr)
  );

`ifdef VRAM_ARBITER_CLIP_EN
  logic w_in_range;
  assign w_in_range = (32'(w_x) < 32'(COLS)) && (32'(w_y) < 32'(ROWS));
  // The transfer still completes (ready was honoured); only the write is dropped.
  assign w_wr_en    = w_transfer && w_in_range;
`else
  assign w_wr_en    = w_transfer;
`endif

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      r_phase      <= 2'd0;
      r_last_gnt   <= 1'b1;
      r_rd_pipe    <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_scan_color <= '0;
    end else begin
      // line_start takes priority over the natural wrap.
      if (line_start || (r_phase == 2'(DIV - 1)))
        r_phase <= 2'd0;
      else
        r_phase <= r_phase + 2'd1;

      if (w_gnt0)
        r_last_gnt <= 1'b0;
      else if (w_gnt1)
        r_last_gnt <= 1'b1;

      r_mem_we <= w_wr_en;
      if (w_scan_slot) begin
        r_mem_addr <= scan_addr;
      end else if (w_wr_en) begin
        r_mem_addr  <= w_addr;
        r_mem_wdata <= w_color;
      end

      // Stage 0 marks the address cycle, the last stage the data cycle.
      r_rd_pipe <= {r_rd_pipe[RD_STAGES-2:0], w_scan_slot};
      if (r_rd_pipe[RD_STAGES-1])
        r_scan_color <= mem_rdata;
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;
  assign scan_color = r_scan_color;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        vga_clock;
  logic        resetn;

  // 160x120 instance (DIV = 4)
  logic        line_start;
  logic        scan_active;
  logic [14:0] scan_addr;
  logic [2:0]  scan_color;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_x, req1_x;
  logic [6:0]  req0_y, req1_y;
  logic [2:0]  req0_color, req1_color;
  logic        req0_ready, req1_ready;
  logic [14:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic        mem_we;
  logic [2:0]  mem_rdata;

  // 640x480 instance (DIV = 1)
  logic        b_line_start;
  logic        b_scan_active;
  logic [18:0] b_scan_addr;
  logic [2:0]  b_scan_color;
  logic        b_req0_valid, b_req1_valid;
  logic [9:0]  b_req0_x, b_req1_x;
  logic [8:0]  b_req0_y, b_req1_y;
  logic [2:0]  b_req0_color, b_req1_color;
  logic        b_req0_ready, b_req1_ready;
  logic [18:0] b_mem_addr;
  logic [2:0]  b_mem_wdata;
  logic        b_mem_we;
  logic [2:0]  b_mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  vram_arbiter dut (
    .vga_clock  (vga_clock),  .resetn     (resetn),
    .line_start (line_start), .scan_active(scan_active),
    .scan_addr  (scan_addr),  .scan_color (scan_color),
    .req0_valid (req0_valid), .req0_x     (req0_x),
    .req0_y     (req0_y),     .req0_color (req0_color),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid), .req1_x     (req1_x),
    .req1_y     (req1_y),     .req1_color (req1_color),
    .req1_ready (req1_ready),
    .mem_addr   (mem_addr),   .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),     .mem_rdata  (mem_rdata)
  );

  vram_arbiter #(
    .RESOLUTION ("640x480"), .COLOR_DEPTH(3), .nX(10), .nY(9), .Mn(19),
    .COLS       (640),       .ROWS       (480)
  ) dut_b (
    .vga_clock  (vga_clock),    .resetn     (resetn),
    .line_start (b_line_start), .scan_active(b_scan_active),
    .scan_addr  (b_scan_addr),  .scan_color (b_scan_color),
    .req0_valid (b_req0_valid), .req0_x     (b_req0_x),
    .req0_y     (b_req0_y),     .req0_color (b_req0_color),
    .req0_ready (b_req0_ready),
    .req1_valid (b_req1_valid), .req1_x     (b_req1_x),
    .req1_y     (b_req1_y),     .req1_color (b_req1_color),
    .req1_ready (b_req1_ready),
    .mem_addr   (b_mem_addr),   .mem_wdata  (b_mem_wdata),
    .mem_we     (b_mem_we),     .mem_rdata  (b_mem_rdata)
  );

  initial vga_clock = 1'b0;
  always #5 vga_clock = ~vga_clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // expected per cycle after reset release, scan_active=1, req0 held valid
  logic [7:0] exp_rdy_a = 8'b1110_1110;  // bit i = cycle i
  logic [7:0] exp_we_a  = 8'b1101_1100;
  int         exp_addr_a [8] = '{0, 100, 323, 323, 323, 100, 323, 323};

  initial begin
    resetn      = 1'b0;
    line_start  = 1'b0;
    scan_active = 1'b1;
    scan_addr   = 15'd100;
    req0_valid  = 1'b1;  req0_x = 8'd3;  req0_y = 7'd2;  req0_color = 3'd5;
    req1_valid  = 1'b0;  req1_x = 8'd0;  req1_y = 7'd0;  req1_color = 3'd0;
    mem_rdata   = 3'd0;
    b_line_start = 1'b0; b_scan_active = 1'b0; b_scan_addr = 19'd0;
    b_req0_valid = 1'b0; b_req0_x = 10'd0; b_req0_y = 9'd0; b_req0_color = 3'd0;
    b_req1_valid = 1'b0; b_req1_x = 10'd0; b_req1_y = 9'd0; b_req1_color = 3'd0;
    b_mem_rdata  = 3'd0;

    repeat (2) @(negedge vga_clock);
    #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_mem_we", mem_we, 0);
    @(negedge vga_clock);
    resetn = 1'b1;

    // scan slots every 4th cycle, req0 granted in the other three
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge vga_clock);
      #1;
      check($sformatf("a_ready0_c%0d", i), req0_ready, exp_rdy_a[i]);
      check($sformatf("a_mem_we_c%0d", i), mem_we, exp_we_a[i]);
      check($sformatf("a_addr_c%0d", i), mem_addr, exp_addr_a[i]);
      if (i == 2) check("a_wdata", mem_wdata, 5);
    end

    // scan read: slot at c8, data presented at c10, visible at c11
    @(negedge vga_clock); req0_valid = 1'b0; #1;
    check("b_ready0_slot", req0_ready, 0);
    @(negedge vga_clock); #1;
    check("b_scan_addr", mem_addr, 100);
    check("b_scan_we", mem_we, 0);
    @(negedge vga_clock); mem_rdata = 3'b101; #1;
    check("b_color_before", scan_color, 0);
    @(negedge vga_clock); mem_rdata = 3'b010; #1;
    check("b_color_t3", scan_color, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge vga_clock); #1;
      check($sformatf("b_color_hold%0d", i), scan_color, 5);
    end
    @(negedge vga_clock); #1;
    check("b_color_next", scan_color, 2);

    // reset values while both requesters are valid
    @(negedge vga_clock);
    resetn = 1'b0; scan_active = 1'b0;
    req0_valid = 1'b1; req0_x = 8'd10;  req0_y = 7'd1;   req0_color = 3'd1;
    req1_valid = 1'b1; req1_x = 8'd159; req1_y = 7'd119; req1_color = 3'd6;
    #1;
    check("r_ready0", req0_ready, 0);
    check("r_ready1", req1_ready, 0);
    check("r_mem_we", mem_we, 0);
    check("r_addr", mem_addr, 0);
    check("r_wdata", mem_wdata, 0);
    check("r_color", scan_color, 0);
    @(negedge vga_clock); resetn = 1'b1;

    // blanking, both valid: 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge vga_clock);
      #1;
      check($sformatf("c_ready0_%0d", i), req0_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("c_ready1_%0d", i), req1_ready, (i % 2 == 1) ? 1 : 0);
      if (i == 1) begin
        check("c_addr0", mem_addr, 170);
        check("c_wdata0", mem_wdata, 1);
      end
      if (i == 2) begin
        check("c_addr1", mem_addr, 19199);
        check("c_wdata1", mem_wdata, 6);
      end
    end

    // reset during a write cycle, no stray write afterwards
    @(negedge vga_clock); req0_valid = 1'b0; req1_valid = 1'b0; #1;
    check("d_we_before", mem_we, 1);
    resetn = 1'b0; #1;
    check("d_we_in_rst", mem_we, 0);
    @(negedge vga_clock); resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("d_we_after%0d", i), mem_we, 0);
      @(negedge vga_clock);
    end

    // line_start at phase 2 restarts the phase sequence
    resetn = 1'b0; scan_active = 1'b1;
    @(negedge vga_clock); resetn = 1'b1;                       // e0 phase 0
    @(negedge vga_clock);                                      // e1 phase 1
    @(negedge vga_clock);                                      // e2 phase 2
    req0_valid = 1'b1; req0_x = 8'd4; req0_y = 7'd0; line_start = 1'b1; #1;
    check("e_ready_ph2", req0_ready, 1);
    @(negedge vga_clock); line_start = 1'b0; #1;               // e3 phase 0
    check("e_ready_ph0", req0_ready, 0);
    check("e_we_ph0", mem_we, 1);
    @(negedge vga_clock); #1;                                  // e4 phase 1
    check("e_ready_ph1", req0_ready, 1);
    check("e_we_ph1", mem_we, 0);
    check("e_scan_addr", mem_addr, 100);
    repeat (3) @(negedge vga_clock);                           // e7 phase 0
    #1;
    check("e_ready_wrap", req0_ready, 0);

    // out-of-range coordinates
    @(negedge vga_clock);
    scan_active = 1'b0; req0_x = 8'd170; req0_y = 7'd5; req0_color = 3'd3; #1;
    check("f_ready", req0_ready, 1);
    @(negedge vga_clock); req0_valid = 1'b0; #1;
`ifdef VRAM_ARBITER_CLIP_EN
    check("f_we_clip", mem_we, 0);
`else
    check("f_we", mem_we, 1);
    check("f_addr", mem_addr, 970);
    check("f_wdata", mem_wdata, 3);
`endif

    // 640x480: no writes while scanning, immediate grant in blanking
    @(negedge vga_clock);
    b_scan_active = 1'b1;
    b_req1_valid = 1'b1; b_req1_x = 10'd600; b_req1_y = 9'd400; b_req1_color = 3'd7;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge vga_clock);
      #1;
      check($sformatf("g_ready1_%0d", i), b_req1_ready, 0);
      check($sformatf("g_we_%0d", i), b_mem_we, 0);
    end
    @(negedge vga_clock); b_scan_active = 1'b0; #1;
    check("g_ready1_blank", b_req1_ready, 1);
    @(negedge vga_clock); b_req1_valid = 1'b0; #1;
    check("g_we", b_mem_we, 1);
    check("g_addr", b_mem_addr, 256600);
    check("g_wdata", b_mem_wdata, 7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
